// File: rtl/memory_stage.sv
// MEM pipeline stage: byte-addressable data memory with sized loads/stores, branch resolve,
// and the MEM/WB register. Misaligned or illegal accesses are suppressed and flagged.
module memory_stage #(
    parameter int unsigned MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Ctl_Branch_in,
    input  logic        Ctl_MemRead_in,
    input  logic        Ctl_MemWrite_in,
    input  logic        Ctl_MemtoReg_in,
    input  logic        Ctl_RegWrite_in,
    input  logic [4:0]  Rd_in,
    input  logic        Zero_in,
    input  logic [31:0] ALUresult_in,
    input  logic [31:0] ReadData2_in,
    input  logic [31:0] PCimm_in,
    input  logic [2:0]  funct3_in,
    output logic        PCSrc_out,
    output logic [31:0] PCimm_out,
    output logic        Ctl_MemtoReg_out,
    output logic        Ctl_RegWrite_out,
    output logic [4:0]  Rd_out,
    output logic [31:0] ReadData_out,
    output logic [31:0] ALUresult_out,
    output logic        Misalign_out
);

    localparam int unsigned IdxW = $clog2(MEM_WORDS);

    // Zero at time zero; reset deliberately leaves the array untouched.
    logic [31:0] mem [MEM_WORDS] = '{default: '0};

    logic [IdxW-1:0] idx;
    logic [1:0]      off;
    logic            access;
    logic            legal;
    logic            do_store;
    logic            do_load;
    logic [3:0]      wmask;
    logic [31:0]     wdata;
    logic [31:0]     rword;
    logic [31:0]     rshift;
    logic [31:0]     load_val;

    assign PCSrc_out = Ctl_Branch_in & Zero_in & ~reset;
    assign PCimm_out = PCimm_in;

    assign idx    = ALUresult_in[IdxW+1:2];
    assign off    = ALUresult_in[1:0];
    assign access = Ctl_MemRead_in | Ctl_MemWrite_in;

    always_comb begin
        legal = 1'b0;
        wmask = 4'b0000;
        wdata = ReadData2_in;
        case (funct3_in)
            3'b000, 3'b100: begin
                legal = 1'b1;
                wmask = 4'b0001 << off;
                wdata = {4{ReadData2_in[7:0]}};
            end
            3'b001, 3'b101: begin
                legal = ~off[0];
                wmask = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{ReadData2_in[15:0]}};
            end
            3'b010: begin
                legal = (off == 2'b00);
                wmask = 4'b1111;
            end
            default: legal = 1'b0;
        endcase
    end

    // A cycle with both flags set is a store only.
    assign do_store = Ctl_MemWrite_in & legal;
    assign do_load  = Ctl_MemRead_in & ~Ctl_MemWrite_in & legal;

    assign rword  = mem[idx];
    assign rshift = rword >> {off, 3'b000};

    always_comb begin
        load_val = '0;
        case (funct3_in)
            3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b100:  load_val = {24'h0, rshift[7:0]};
            3'b001:  load_val = {{16{rshift[15]}}, rshift[15:0]};
            3'b101:  load_val = {16'h0, rshift[15:0]};
            3'b010:  load_val = rword;
            default: load_val = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && do_store) begin
            for (int i = 0; i < 4; i++) begin
                if (wmask[i]) begin
                    mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            Ctl_MemtoReg_out <= 1'b0;
            Ctl_RegWrite_out <= 1'b0;
            Rd_out           <= '0;
            ReadData_out     <= '0;
            ALUresult_out    <= '0;
            Misalign_out     <= 1'b0;
        end else begin
            Ctl_MemtoReg_out <= Ctl_MemtoReg_in;
            Ctl_RegWrite_out <= Ctl_RegWrite_in;
            Rd_out           <= Rd_in;
            ReadData_out     <= do_load ? load_val : 32'h0;
            ALUresult_out    <= ALUresult_in;
            Misalign_out     <= access & ~legal;
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: stores/loads of every size, misalignment, branch, wrap, reset.
module tb_memory_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        Ctl_Branch_in = 1'b0, Ctl_MemRead_in = 1'b0, Ctl_MemWrite_in = 1'b0;
    logic        Ctl_MemtoReg_in = 1'b0, Ctl_RegWrite_in = 1'b0;
    logic [4:0]  Rd_in = '0;
    logic        Zero_in = 1'b0;
    logic [31:0] ALUresult_in = '0, ReadData2_in = '0, PCimm_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        PCSrc_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Misalign_out;
    logic [31:0] PCimm_out, ReadData_out, ALUresult_out;
    logic [4:0]  Rd_out;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    memory_stage #(.MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .Ctl_Branch_in(Ctl_Branch_in), .Ctl_MemRead_in(Ctl_MemRead_in),
        .Ctl_MemWrite_in(Ctl_MemWrite_in), .Ctl_MemtoReg_in(Ctl_MemtoReg_in),
        .Ctl_RegWrite_in(Ctl_RegWrite_in), .Rd_in(Rd_in), .Zero_in(Zero_in),
        .ALUresult_in(ALUresult_in), .ReadData2_in(ReadData2_in), .PCimm_in(PCimm_in),
        .funct3_in(funct3_in), .PCSrc_out(PCSrc_out), .PCimm_out(PCimm_out),
        .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
        .Rd_out(Rd_out), .ReadData_out(ReadData_out), .ALUresult_out(ALUresult_out),
        .Misalign_out(Misalign_out)
    );

    // Present one memory access and advance to just after the capturing edge.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] data);
        Ctl_MemRead_in  = rd;
        Ctl_MemWrite_in = wr;
        funct3_in       = f3;
        ALUresult_in    = addr;
        ReadData2_in    = data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        Ctl_Branch_in = 1'b1; Zero_in = 1'b1; Ctl_MemtoReg_in = 1'b1; Ctl_RegWrite_in = 1'b1;
        Rd_in = 5'd7; ALUresult_in = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (PCSrc_out !== 1'b0) begin n_bad++; $display("FAIL rst_pcsrc got %b want 0", PCSrc_out); end
        @(posedge clk); #1;
        n_cmp++; if ({Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out, Misalign_out} !== 8'h0) begin
            n_bad++; $display("FAIL rst_ctl got %b%b %h %b want 0", Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out, Misalign_out); end
        n_cmp++; if ({ReadData_out, ALUresult_out} !== 64'h0) begin
            n_bad++; $display("FAIL rst_data got %h %h want 0", ReadData_out, ALUresult_out); end
        Ctl_Branch_in = 1'b0; Zero_in = 1'b0; Ctl_MemtoReg_in = 1'b0; Ctl_RegWrite_in = 1'b0;
        Rd_in = '0; ALUresult_in = '0;
        reset = 1'b0;
    endtask

    task automatic test_word();
        access(1'b0, 1'b1, 3'b010, 32'd8, 32'h8765_4321);
        n_cmp++; if (ReadData_out !== 32'h0) begin n_bad++; $display("FAIL sw_rdata got %h want 0", ReadData_out); end
        Ctl_MemtoReg_in = 1'b1; Ctl_RegWrite_in = 1'b1; Rd_in = 5'd5;
        access(1'b1, 1'b0, 3'b010, 32'd8, 32'h0);
        n_cmp++; if (ReadData_out !== 32'h8765_4321) begin n_bad++; $display("FAIL lw_data got %h want 87654321", ReadData_out); end
        n_cmp++; if ({Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out} !== {2'b11, 5'd5}) begin
            n_bad++; $display("FAIL lw_ctl got %b%b %0d want 11 5", Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out); end
        n_cmp++; if (ALUresult_out !== 32'd8) begin n_bad++; $display("FAIL lw_alu got %h want 8", ALUresult_out); end
        Ctl_MemtoReg_in = 1'b0; Ctl_RegWrite_in = 1'b0; Rd_in = '0;
    endtask

    task automatic test_byte();
        access(1'b0, 1'b1, 3'b010, 32'd8, 32'h0);
        access(1'b0, 1'b1, 3'b000, 32'd9, 32'h1234_56AB);
        access(1'b1, 1'b0, 3'b000, 32'd9, 32'h0);
        n_cmp++; if (ReadData_out !== 32'hFFFF_FFAB) begin n_bad++; $display("FAIL lb got %h want ffffffab", ReadData_out); end
        access(1'b1, 1'b0, 3'b100, 32'd9, 32'h0);
        n_cmp++; if (ReadData_out !== 32'h0000_00AB) begin n_bad++; $display("FAIL lbu got %h want 000000ab", ReadData_out); end
        access(1'b1, 1'b0, 3'b010, 32'd8, 32'h0);
        n_cmp++; if (ReadData_out !== 32'h0000_AB00) begin n_bad++; $display("FAIL lb_word got %h want 0000ab00", ReadData_out); end
    endtask

    task automatic test_half();
        access(1'b0, 1'b1, 3'b001, 32'd6, 32'hFFFF_8001);
        access(1'b1, 1'b0, 3'b001, 32'd6, 32'h0);
        n_cmp++; if (ReadData_out !== 32'hFFFF_8001) begin n_bad++; $display("FAIL lh got %h want ffff8001", ReadData_out); end
        access(1'b1, 1'b0, 3'b101, 32'd6, 32'h0);
        n_cmp++; if (ReadData_out !== 32'h0000_8001) begin n_bad++; $display("FAIL lhu got %h want 00008001", ReadData_out); end
        n_cmp++; if (Misalign_out !== 1'b0) begin n_bad++; $display("FAIL lhu_mis got %b want 0", Misalign_out); end
        access(1'b0, 1'b1, 3'b010, 32'd5, 32'hFFFF_FFFF);
        n_cmp++; if ({Misalign_out, ReadData_out} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL sw_mis got %b %h want 1 0", Misalign_out, ReadData_out); end
        access(1'b1, 1'b0, 3'b001, 32'd7, 32'h0);
        n_cmp++; if ({Misalign_out, ReadData_out} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL lh_mis got %b %h want 1 0", Misalign_out, ReadData_out); end
        access(1'b1, 1'b0, 3'b010, 32'd4, 32'h0);
        n_cmp++; if ({Misalign_out, ReadData_out} !== {1'b0, 32'h8001_0000}) begin
            n_bad++; $display("FAIL mis_nowrite got %b %h want 0 80010000", Misalign_out, ReadData_out); end
    endtask

    task automatic test_branch();
        Ctl_Branch_in = 1'b1; Zero_in = 1'b1; PCimm_in = 32'd20;
        #1;
        n_cmp++; if ({PCSrc_out, PCimm_out} !== {1'b1, 32'd20}) begin
            n_bad++; $display("FAIL br_taken got %b %0d want 1 20", PCSrc_out, PCimm_out); end
        Zero_in = 1'b0;
        #1;
        n_cmp++; if (PCSrc_out !== 1'b0) begin n_bad++; $display("FAIL br_nottaken got %b want 0", PCSrc_out); end
        Ctl_Branch_in = 1'b0;
    endtask

    task automatic test_wrap_illegal();
        access(1'b0, 1'b1, 3'b010, 32'h400, 32'd5);
        access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        n_cmp++; if (ReadData_out !== 32'd5) begin n_bad++; $display("FAIL wrap got %h want 5", ReadData_out); end
        access(1'b0, 1'b1, 3'b110, 32'h0, 32'hFFFF_FFFF);
        n_cmp++; if (Misalign_out !== 1'b1) begin n_bad++; $display("FAIL f3_110_mis got %b want 1", Misalign_out); end
        access(1'b1, 1'b0, 3'b011, 32'h0, 32'h0);
        n_cmp++; if ({Misalign_out, ReadData_out} !== {1'b1, 32'h0}) begin
            n_bad++; $display("FAIL f3_011_mis got %b %h want 1 0", Misalign_out, ReadData_out); end
        access(1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
        n_cmp++; if (ReadData_out !== 32'd5) begin n_bad++; $display("FAIL f3_110_nowrite got %h want 5", ReadData_out); end
        access(1'b0, 1'b0, 3'b010, 32'h0, 32'h0);
        n_cmp++; if ({Misalign_out, ReadData_out} !== {1'b0, 32'h0}) begin
            n_bad++; $display("FAIL idle got %b %h want 0 0", Misalign_out, ReadData_out); end
    endtask

    task automatic test_both_flags();
        access(1'b1, 1'b1, 3'b010, 32'd12, 32'h55);
        n_cmp++; if (ReadData_out !== 32'h0) begin n_bad++; $display("FAIL both_rdata got %h want 0", ReadData_out); end
        access(1'b1, 1'b0, 3'b010, 32'd12, 32'h0);
        n_cmp++; if (ReadData_out !== 32'h55) begin n_bad++; $display("FAIL both_store got %h want 55", ReadData_out); end
    endtask

    task automatic test_reset_mid();
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFE_F00D);
        Ctl_MemtoReg_in = 1'b1; Ctl_RegWrite_in = 1'b1; Rd_in = 5'd9;
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        n_cmp++; if (ReadData_out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL pre_rst got %h want cafef00d", ReadData_out); end
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({ReadData_out, ALUresult_out, Rd_out, Ctl_MemtoReg_out, Ctl_RegWrite_out, Misalign_out} !== 72'h0) begin
            n_bad++; $display("FAIL async_rst got %h %h %0d %b%b%b want 0", ReadData_out, ALUresult_out, Rd_out,
                              Ctl_MemtoReg_out, Ctl_RegWrite_out, Misalign_out); end
        access(1'b0, 1'b1, 3'b010, 32'h20, 32'h1111_1111);
        n_cmp++; if ({ReadData_out, ALUresult_out, Rd_out} !== 69'h0) begin
            n_bad++; $display("FAIL rst_hold got %h %h %0d want 0", ReadData_out, ALUresult_out, Rd_out); end
        reset = 1'b0;
        access(1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        n_cmp++; if (ReadData_out !== 32'hCAFE_F00D) begin n_bad++; $display("FAIL post_rst got %h want cafef00d", ReadData_out); end
        n_cmp++; if (Rd_out !== 5'd9) begin n_bad++; $display("FAIL post_rst_rd got %0d want 9", Rd_out); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_branch();
        test_wrap_illegal();
        test_both_flags();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/memory_stage.md
MEMORY_STAGE -- requirements
Module: memory_stage

Interface
REQ-001 Parameter MEM_WORDS, default 256, meaning data-memory depth in 32-bit words; fixed at 256 for this release.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 Ctl_Branch_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_MemtoReg_in, Ctl_RegWrite_in  input  1 each  control bits from the EX/MEM register.
REQ-005 Rd_in  input  5  destination register index.
REQ-006 Zero_in  input  1  ALU zero flag.
REQ-007 ALUresult_in  input  32  byte address for loads and stores, or the result to pass through.
REQ-008 ReadData2_in  input  32  store data.
REQ-009 PCimm_in  input  32  branch target.
REQ-010 funct3_in  input  3  access size: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-011 PCSrc_out  output  1  branch-taken select to fetch.
REQ-012 PCimm_out  output  32  branch target to fetch.
REQ-013 Ctl_MemtoReg_out, Ctl_RegWrite_out  output  1 each  MEM/WB control.
REQ-014 Rd_out  output  5  MEM/WB destination register.
REQ-015 ReadData_out  output  32  MEM/WB load data.
REQ-016 ALUresult_out  output  32  MEM/WB ALU result.
REQ-017 Misalign_out  output  1  MEM/WB flag: the previous access was misaligned or illegal.

Function
REQ-018 PCSrc_out SHALL equal Ctl_Branch_in AND Zero_in, combinationally; it SHALL be forced to 0 while reset is high.
REQ-019 PCimm_out SHALL equal PCimm_in, combinationally.
REQ-020 The memory word index SHALL be ALUresult_in[9:2]; higher address bits are ignored, so addresses wrap modulo 1024 bytes.
REQ-021 Access selection: MemWrite=1 is a store; MemRead=1 with MemWrite=0 is a load; if both are 1, the cycle is a store only.
REQ-022 Stores SHALL commit at the rising clk edge, with byte-lane enables as follows:
- sb: lane ALUresult_in[1:0] receives ReadData2_in[7:0].
- sh: lanes {a1,0} and {a1,1} receive ReadData2_in[15:0].
- sw: all 4 lanes receive ReadData2_in.
- Unwritten lanes are preserved.
REQ-023 Loads SHALL be synchronous: the addressed word is read at the rising edge, then extracted and extended into ReadData_out in the same edge, giving 1-cycle latency.
- lb and lh sign-extend; lbu and lhu zero-extend; lw is unmodified.
REQ-024 When no load occurs (a store, no access, or both flags 0), ReadData_out SHALL be loaded with 0.
REQ-025 Misaligned accesses SHALL be suppressed: h/hu with address bit 0 set, or w with address bits [1:0] nonzero.
- No lanes are written.
- ReadData_out is 0.
- Misalign_out is 1 for that MEM/WB cycle.
REQ-026 funct3 values 011, 110 and 111 with MemRead or MemWrite set SHALL be treated as suppressed accesses, per REQ-025.
REQ-027 Misalign_out SHALL be 0 for all other cycles, including cycles with no memory access.
REQ-028 Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out and ALUresult_out SHALL register their inputs every rising edge, with no stall and no enable.
REQ-029 A load at address A in cycle n+1, following a store to A in cycle n, SHALL return the stored data.
REQ-030 Memory contents SHALL initialise to 0 at time zero.

Reset
REQ-031 While reset=1, all MEM/WB outputs (Ctl_MemtoReg_out, Ctl_RegWrite_out, Rd_out, ReadData_out, ALUresult_out, Misalign_out) SHALL be 0 immediately, without waiting for a clock edge.
REQ-032 While reset=1, no store SHALL commit.
REQ-033 Memory array contents SHALL NOT be cleared by reset.
REQ-034 Reset asserted mid-operation SHALL discard the in-flight load result.
- The first rising edge after reset deassertion resumes normal operation.

Verification
REQ-035 sw: addr 8, data 0x8765_4321; then lw at addr 8 -> ReadData_out=0x8765_4321 one cycle after the load; MemtoReg and Rd propagate.
REQ-036 sb: data 0xAB at addr 9 over a word of 0; then lb at 9 -> 0xFFFF_FFAB; lbu at 9 -> 0x0000_00AB; lw at 8 -> 0x0000_AB00.
REQ-037 sh at addr 6 with 0x8001; then lh at 6 -> 0xFFFF_8001; lhu -> 0x0000_8001; sw at addr 5 -> no write, Misalign_out=1, and the word at 4 is unchanged.
REQ-038 Branch=1, Zero=1, PCimm=20 -> PCSrc_out=1 and PCimm_out=20 in the same cycle; Zero=0 -> PCSrc_out=0.
REQ-039 Wrap: sw at addr 0x400 with 5 -> lw at 0 returns 5.
REQ-040 Reset sequence:
- Assert reset mid-load -> all outputs 0 asynchronously.
- A store issued during reset does not commit.
- Memory written before reset still reads back after deassertion.
